// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving a req/ready data bus and stalling the pipe.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state;
  logic r_byte, r_half, r_uns;
  logic [1:0] r_lane;
  logic w_access, w_byte, w_half, w_trap, w_start;
  logic [3:0] w_be;
  logic [XLEN-1:0] w_wdata, w_ext;
  logic [4:0] w_sh;
  logic [15:0] w_rsh;
  assign w_access = MemWriteM | (ResultSrcM == 2'b01);
  // Undefined funct3 codes fall back to word; 100/101 are only meaningful for loads.
  assign w_byte = (Funct3M == 3'b000) | (~MemWriteM & (Funct3M == 3'b100));
  assign w_half = (Funct3M == 3'b001) | (~MemWriteM & (Funct3M == 3'b101));
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_half & ALUResultM[0]) | (~w_byte & ~w_half & (|ALUResultM[1:0]));
`else
  assign w_trap = 1'b0;
`endif
  assign w_start = (r_state == IDLE) & w_access;
  assign StallM = ~reset & ((w_start & ~w_trap) | (r_state == BUSY));
  assign w_be = w_byte ? 4'(4'b0001 << ALUResultM[1:0]) : w_half ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata = w_byte ? {4{WriteDataM[7:0]}} : w_half ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign w_sh = r_byte ? {r_lane, 3'b000} : r_half ? {r_lane[1], 4'b0000} : 5'd0;
  assign w_rsh = 16'(mem_rdata >> w_sh);
  assign w_ext = r_byte ? {{24{~r_uns & w_rsh[7]}}, w_rsh[7:0]} :
                 r_half ? {{16{~r_uns & w_rsh[15]}}, w_rsh} : mem_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_byte    <= 1'b0;
      r_half    <= 1'b0;
      r_uns     <= 1'b0;
      r_lane    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      ReadDataM <= '0;
      MisalignM <= 1'b0;
    end else begin
      MisalignM <= w_start & w_trap;
      if (w_start && w_trap) begin
        r_state <= DONE;
      end else if (w_start) begin
        r_state   <= BUSY;
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
        mem_wdata <= w_wdata;
        mem_be    <= w_be;
        r_byte    <= w_byte;
        r_half    <= w_half;
        r_uns     <= Funct3M[2];
        r_lane    <= ALUResultM[1:0];
      end else if (r_state == BUSY && mem_ready) begin
        r_state <= DONE;
        mem_req <= 1'b0;
        if (!mem_we) ReadDataM <= w_ext;
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench for mem_stage_lsu with a behavioural bus/load model.
module tb_mem_stage_lsu;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
  logic MemWriteM = 1'b1, mem_ready = 1'b0;
  logic [1:0] ResultSrcM = 2'b01;
  logic [2:0] Funct3M = 3'b010;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic StallM, MisalignM, mem_req, mem_we;
  logic [3:0] mem_be;
  int n_chk = 0, n_pass = 0;
  logic [31:0] model_rd = '0;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One EX/MEM instruction held until the unit releases it; the bench plays the memory.
  task automatic do_access(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int dly);
    logic load;
    int sz, stall, waited;
    bit done;
    logic [31:0] e_be, e_wd, v;
    load = !we && rs == 2'b01;
    sz = we ? (f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4)
            : ((f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    e_be = sz == 1 ? (32'd1 << a[1:0]) : sz == 2 ? (a[1] ? 32'd12 : 32'd3) : 32'd15;
    e_wd = sz == 1 ? {24'd0, wd[7:0]} * 32'h0101_0101 : sz == 2 ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
    v = rd >> (sz == 1 ? 8 * a[1:0] : sz == 2 ? 16 * a[1] : 0);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    stall = 0; waited = 0; done = 0;
    @(posedge clk); #1;
    MemWriteM = we; ResultSrcM = rs; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    if (!(we || rs == 2'b01)) begin
      @(negedge clk);
      chk("idle_stall", StallM, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_rdata", ReadDataM, model_rd);
    end else begin
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge clk);
        if (!StallM) done = 1;
        else begin
          stall++;
          if (mem_req) begin
            chk("bus_we", mem_we, we);
            chk("bus_addr", mem_addr, {a[31:2], 2'b00});
            chk("bus_be", mem_be, e_be);
            if (we) chk("bus_wdata", mem_wdata, e_wd);
          end
        end
        mem_ready = mem_req ? (waited >= dly) : 1'($urandom);
        mem_rdata = mem_req ? rd : $urandom;
        if (mem_req) waited++;
      end
      chk("timeout", 32'(done), 1);
      if (load) model_rd = v;
      chk("stall_cycles", stall, dly + 2);
      chk("read_data", ReadDataM, model_rd);
      chk("done_req", mem_req, 0);
      chk("misalign_quiet", MisalignM, 0);
    end
    @(posedge clk); #1;
    MemWriteM = 1'b0; ResultSrcM = 2'b00;
  endtask

  initial begin
    #12;
    chk("rst_stall", StallM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_mis", MisalignM, 0);
    MemWriteM = 1'b0; ResultSrcM = 2'b00;
    @(negedge clk); reset = 1'b0;
    // Reset while a load waits on the bus: request must drop at once, nothing captured.
    @(posedge clk); #1;
    ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h200; mem_ready = 1'b0;
    @(negedge clk); chk("rb_stall_idle", StallM, 1);
    @(negedge clk); chk("rb_req_busy", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rb_req_drop", mem_req, 0);
    chk("rb_stall", StallM, 0);
    chk("rb_rdata", ReadDataM, 0);
    ResultSrcM = 2'b00; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rb_rdata_after", ReadDataM, 0);
    chk("rb_req_after", mem_req, 0);
    mem_ready = 1'b0;
    model_rd = '0;
    do_access(1, 2'b00, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    do_access(0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    chk("lb_value", ReadDataM, 32'hFFFF_FF80);
    do_access(0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 1);
    chk("lbu_value", ReadDataM, 32'h0000_0080);
    do_access(1, 2'b00, 3'b001, 32'h22, 32'h0000_CAFE, 32'h0, 3);
    chk("sh_keeps_rdata", ReadDataM, 32'h0000_0080);
    do_access(0, 2'b01, 3'b001, 32'h102, 32'h0, 32'h9ABC_1234, 2);
    chk("lh_value", ReadDataM, 32'hFFFF_9ABC);
    do_access(0, 2'b01, 3'b101, 32'h102, 32'h0, 32'h9ABC_1234, 0);
    chk("lhu_value", ReadDataM, 32'h0000_9ABC);
`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h102;
    @(negedge clk);
    chk("mis_stall", StallM, 0);
    chk("mis_req", mem_req, 0);
    @(negedge clk);
    chk("mis_pulse", MisalignM, 1);
    chk("mis_req_done", mem_req, 0);
    chk("mis_stall_done", StallM, 0);
    chk("mis_rdata", ReadDataM, model_rd);
    @(posedge clk); #1; ResultSrcM = 2'b00;
    @(negedge clk);
    chk("mis_pulse_end", MisalignM, 0);
`endif
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      a[1:0] = 2'b00;
`endif
      do_access(1'($urandom_range(0, 2) == 0), 2'($urandom), 3'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
